dm_sba_engine: RTL
==================

Name: dm_sba_engine

Overview:
Parametrised System Bus Access master for the debug module, the successor of the fixed-width Idle/Read/Write/WaitRead/WaitWrite SBA sequencer. It sits between the DM CSR block (sbcs/sbaddress/sbdata fields) and a req/gnt/rvalid system bus. It supports configurable bus width, 8..64-bit access sizes with byte-lane steering, autoincrement, read-on-address, read-on-data, sticky sberror codes and sbbusyerror.

Parameters:
BusWidth, 32, system bus data/address width; legal values 32 or 64
TimeoutCycles, 1024, bus-stall abort limit; used only with DM_SBA_TIMEOUT_EN

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
sbaddress_i  in  BusWidth  new sbaddress value from DMI write
sbaddress_we_i  in  1  sbaddress write strobe
sbdata_i  in  BusWidth  new sbdata value from DMI write
sbdata_we_i  in  1  sbdata write strobe; starts a bus write
sbdata_re_i  in  1  sbdata read strobe from DMI
sbaccess_i  in  3  access size code; size = 1<<sbaccess bytes
sbautoincrement_i  in  1  after each successful access, add the size to the address
sbreadonaddr_i  in  1  sbaddress write starts a bus read
sbreadondata_i  in  1  sbdata read starts a bus read
sberror_clr_i  in  1  clears sberror_o
sbbusyerror_clr_i  in  1  clears sbbusyerror_o
sbaddress_o  out  BusWidth  current address register
sbdata_o  out  BusWidth  data register, zero-extended read result
sbdata_valid_o  out  1  one-cycle pulse when a read completes
sbbusy_o  out  1  state != Idle
sberror_o  out  3  sticky error code
sbbusyerror_o  out  1  sticky busy error
req_o  out  1  bus request
we_o  out  1  bus write enable
addr_o  out  BusWidth  word-aligned bus address
wdata_o  out  BusWidth  lane-steered write data
be_o  out  BusWidth/8  byte enables
gnt_i  in  1  bus grant
rvalid_i  in  1  bus response valid; never asserted in the same cycle as gnt_i
rdata_i  in  BusWidth  read data
err_i  in  1  bus error, qualified by rvalid_i

Behaviour:
- Reset: all state is synchronous to clk_i. When rst_ni is low, the FSM goes to Idle and every output is 0.
- Reset mid-operation: the engine returns to Idle immediately. Any late rvalid_i is ignored, because rvalid_i is only sampled in WaitRead/WaitWrite.
- FSM states: Idle, Read, Write, WaitRead, WaitWrite.
- Idle, event priority (one event per cycle): sbaddress_we_i > sbdata_we_i > sbdata_re_i.
- Idle, sbaddress_we_i: load sbaddress_o; go to Read if sbreadonaddr_i is set.
- Idle, sbdata_we_i: load sbdata_o; go to Write.
- Idle, sbdata_re_i with sbreadondata_i set: go to Read. sbdata_o keeps its old value until the read returns.
- Starting an access: no access starts while sberror_o != 0 or sbbusyerror_o = 1. Register loads still occur.
- Size check before leaving Idle: if sbaccess > 3, or (8<<sbaccess) > BusWidth, set sberror_o = 4 and stay Idle.
- Alignment check before leaving Idle: if the address is not aligned to the access size, set sberror_o = 3 and stay Idle.
- Read/Write: req_o = 1; we_o = 1 in Write only. addr_o = sbaddress_o with the low log2(BusWidth/8) bits cleared.
- Byte enables: be_o = ((1<<size)-1) << off, where off = the low address bits.
- Write data: wdata_o = sbdata_o << (8*off).
- Request hold: req_o, addr_o, we_o, be_o and wdata_o stay stable until gnt_i. On gnt_i go to WaitRead or WaitWrite; req_o = 0 from the next cycle.
- WaitRead on rvalid_i with !err_i: sbdata_o = (rdata_i >> 8*off) masked to the size, zero-extended. Pulse sbdata_valid_o for one cycle; return to Idle.
- WaitWrite on rvalid_i with !err_i: return to Idle.
- Autoincrement: on successful completion with sbautoincrement_i set, sbaddress_o += size, modulo 2^BusWidth (wraps silently).
- Bus error: rvalid_i with err_i sets sberror_o = 2. No increment, sbdata_o unchanged, return to Idle.
- Busy error: sbaddress_we_i, sbdata_we_i or sbdata_re_i while sbbusy_o = 1 sets sbbusyerror_o. The write is discarded and registers are unchanged.
- Error clears: sberror_clr_i and sbbusyerror_clr_i clear their flag next cycle. If a new error is raised in the same cycle as its clear, the error wins.
- Latency: Idle to req_o is 1 cycle; completion to sbbusy_o = 0 is 1 cycle.

Optional Feature:
DM_SBA_TIMEOUT_EN: a counter runs in Read, Write, WaitRead and WaitWrite and resets on every state change. When it reaches TimeoutCycles: set sberror_o = 1, drop req_o and go to Idle, abandoning the access. Without the macro: no counter, and the engine waits indefinitely.

Test Plan:
- BusWidth=32, sbaccess=2, sbreadonaddr=1, address write 0x1000 -> req_o=1, addr_o=0x1000, be_o=0xF, we_o=0. After gnt_i and rvalid_i with rdata_i=0xDEADBEEF -> sbdata_o=0xDEADBEEF, one sbdata_valid_o pulse, sbaddress_o stays 0x1000.
- sbaccess=0, autoincrement=1, sbaddress=0x1003, sbdata write 0xA5 -> addr_o=0x1000, be_o=0x8, wdata_o[31:24]=0xA5; after response, sbaddress_o=0x1004.
- BusWidth=32, sbaccess=3 -> sberror_o=4, req_o never asserted. sbaccess=1 at address 0x1001 -> sberror_o=3. New accesses are blocked until sberror_clr_i.
- sbdata write while a read is stalled (gnt_i=0) -> sbbusyerror_o=1 and sbdata_o unchanged. After completion, the next access is blocked until sbbusyerror_clr_i.
- Read returns rvalid_i with err_i=1 -> sberror_o=2, sbaddress_o unchanged, sbdata_o unchanged, no sbdata_valid_o pulse.
- With DM_SBA_TIMEOUT_EN and TimeoutCycles=16, gnt_i held at 0 -> sberror_o=1 and req_o=0 after 16 cycles, FSM in Idle. rst_ni low mid-access -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/dm_sba_engine.sv
// dm_sba_engine: debug-module System Bus Access master (sbcs/sbaddress/sbdata -> req/gnt/rvalid bus).
// Latency: req_o one cycle after the triggering DMI strobe; sbbusy_o drops one cycle after rvalid_i.
// Backpressure: request held stable until gnt_i; DMI strobes while busy are dropped and set sbbusyerror_o.
// Optional: define DM_SBA_TIMEOUT_EN to abandon stalled accesses after TimeoutCycles with sberror_o = 1.
module dm_sba_engine #(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_we_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_we_i,
    input  logic                  sbdata_re_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbautoincrement_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbreadondata_i,
    input  logic                  sberror_clr_i,
    input  logic                  sbbusyerror_clr_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic [2:0]            sberror_o,
    output logic                  sbbusyerror_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [BusWidth-1:0]   addr_o,
    output logic [BusWidth-1:0]   wdata_o,
    output logic [BusWidth/8-1:0] be_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic [BusWidth-1:0]   rdata_i,
    input  logic                  err_i
);
    localparam int unsigned BeW       = BusWidth / 8;
    localparam int unsigned OffW      = $clog2(BeW);
    localparam logic [2:0]  MaxAccess = (BusWidth == 64) ? 3'd3 : 3'd2;

    typedef enum logic [2:0] {Idle, Read, Write, WaitRead, WaitWrite} state_e;

    state_e              state_q, state_d;
    logic [BusWidth-1:0] sbaddress_q, sbaddress_d, sbdata_q, sbdata_d;
    logic [2:0]          sberror_q, sberror_d;
    logic                sbbusyerror_q, sbbusyerror_d;
    logic                sbdata_valid_q, sbdata_valid_d;
    logic [1:0]          size_q, size_d;

    logic [OffW-1:0]     off;
    logic [BeW-1:0]      be_base;
    logic [6:0]          size_bits;
    logic [BusWidth-1:0] rdata_mask, incr_addr, chk_addr;
    logic [2:0]          chk_err;
    logic                start_ok, start_rd, start_wr, timeout;

    // Size is latched at access start so a mid-access sbcs write cannot disturb lane steering.
    assign off        = sbaddress_q[OffW-1:0];
    assign size_bits  = 7'd8 << size_q;
    assign be_base    = BeW'((16'd1 << (5'd1 << size_q)) - 16'd1);
    assign rdata_mask = ~({BusWidth{1'b1}} << size_bits);
    assign incr_addr  = sbaddress_q + (BusWidth'(1) << size_q);
    assign chk_addr   = sbaddress_we_i ? sbaddress_i : sbaddress_q;
    assign start_ok   = (sberror_q == 3'd0) && !sbbusyerror_q;

    always_comb begin
        chk_err = 3'd0;
        if (sbaccess_i > MaxAccess) begin
            chk_err = 3'd4;
        end else if ((chk_addr & ((BusWidth'(1) << sbaccess_i) - BusWidth'(1))) != '0) begin
            chk_err = 3'd3;
        end
    end

    always_comb begin
        state_d        = state_q;
        sbaddress_d    = sbaddress_q;
        sbdata_d       = sbdata_q;
        size_d         = size_q;
        sbdata_valid_d = 1'b0;
        sberror_d      = sberror_clr_i ? 3'd0 : sberror_q;
        sbbusyerror_d  = sbbusyerror_clr_i ? 1'b0 : sbbusyerror_q;
        start_rd       = 1'b0;
        start_wr       = 1'b0;
        case (state_q)
            Idle: begin
                if (sbaddress_we_i) begin
                    sbaddress_d = sbaddress_i;
                    start_rd    = sbreadonaddr_i;
                end else if (sbdata_we_i) begin
                    sbdata_d = sbdata_i;
                    start_wr = 1'b1;
                end else if (sbdata_re_i) begin
                    start_rd = sbreadondata_i;
                end
                if ((start_rd || start_wr) && start_ok) begin
                    if (chk_err != 3'd0) begin
                        sberror_d = chk_err;
                    end else begin
                        state_d = start_wr ? Write : Read;
                        size_d  = sbaccess_i[1:0];
                    end
                end
            end
            Read:  if (gnt_i) state_d = WaitRead;
            Write: if (gnt_i) state_d = WaitWrite;
            WaitRead, WaitWrite: begin
                if (rvalid_i) begin
                    state_d = Idle;
                    if (err_i) begin
                        sberror_d = 3'd2;
                    end else begin
                        if (state_q == WaitRead) begin
                            sbdata_d       = (rdata_i >> {off, 3'b000}) & rdata_mask;
                            sbdata_valid_d = 1'b1;
                        end
                        if (sbautoincrement_i) sbaddress_d = incr_addr;
                    end
                end
            end
            default: state_d = Idle;
        endcase
        if (state_q != Idle && (sbaddress_we_i || sbdata_we_i || sbdata_re_i)) begin
            sbbusyerror_d = 1'b1;
        end
        if (timeout && state_d == state_q) begin
            state_d   = Idle;
            sberror_d = 3'd1;
        end
    end

`ifdef DM_SBA_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || state_q == Idle || state_d != state_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end
    assign timeout = (state_q != Idle) && (cnt_q == CntW'(TimeoutCycles - 1));
`else
    assign timeout = 1'b0 & (TimeoutCycles == 32'd0);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= Idle;
            sbaddress_q    <= '0;
            sbdata_q       <= '0;
            sberror_q      <= 3'd0;
            sbbusyerror_q  <= 1'b0;
            sbdata_valid_q <= 1'b0;
            size_q         <= 2'd0;
        end else begin
            state_q        <= state_d;
            sbaddress_q    <= sbaddress_d;
            sbdata_q       <= sbdata_d;
            sberror_q      <= sberror_d;
            sbbusyerror_q  <= sbbusyerror_d;
            sbdata_valid_q <= sbdata_valid_d;
            size_q         <= size_d;
        end
    end

    assign sbaddress_o    = sbaddress_q;
    assign sbdata_o       = sbdata_q;
    assign sbdata_valid_o = sbdata_valid_q;
    assign sberror_o      = sberror_q;
    assign sbbusyerror_o  = sbbusyerror_q;
    assign sbbusy_o       = (state_q != Idle);
    assign req_o          = (state_q == Read) || (state_q == Write);
    assign we_o           = (state_q == Write);
    assign addr_o         = req_o ? {sbaddress_q[BusWidth-1:OffW], {OffW{1'b0}}} : '0;
    assign be_o           = req_o ? (be_base << off) : '0;
    assign wdata_o        = we_o ? (sbdata_q << {off, 3'b000}) : '0;
endmodule
